// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even ratios.
// Ratio changes take effect only at period boundaries, so clk_out never produces a runt pulse.
module clk_div_prog #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             load_err,
    output logic             running
);

    localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] One    = DIV_W'(1);
    localparam logic [DIV_W-1:0] Two    = DIV_W'(2);
    localparam logic [DIV_W:0]   OneW   = (DIV_W+1)'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             run_q, run_d;

    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W:0]   half;
    logic             last;
    logic             legal;
    logic             apply;

    assign cnt_inc = cnt_q + One;
    // ceil(N/2): number of clk cycles in which pos_q is high
    assign half    = ({1'b0, div_q} + OneW) >> 1;
    assign last    = (cnt_q == (div_q - One));
    assign legal   = (div_val >= Two);

    // Next-state: counter, phase, boundary handling and pending-ratio capture
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pos_d      = pos_q;
        tick_d     = 1'b0;
        run_d      = run_q;
        apply      = 1'b0;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = 1'b0;

        if (run_q && !last) begin
            cnt_d = cnt_inc;
            pos_d = ({1'b0, cnt_inc} < half);
        end else if (run_q || en) begin
            // Boundary: wrap of a running period, or start from idle
            apply = pend_vld_q;
            cnt_d = '0;
            if (pend_vld_q) begin
                div_d = pend_q;
            end
            if (en) begin
                run_d  = 1'b1;
                tick_d = 1'b1;
                pos_d  = 1'b1;
            end else begin
                run_d = 1'b0;
                pos_d = 1'b0;
            end
        end else begin
            cnt_d = '0;
            pos_d = 1'b0;
        end

        // A load on the boundary edge becomes the next pending value
        if (div_load && legal) begin
            pend_d     = div_val;
            pend_vld_d = 1'b1;
        end else if (apply) begin
            pend_vld_d = 1'b0;
        end
        err_d = div_load && !legal;
    end

    // Posedge state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            div_q      <= DefDiv;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            pos_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            pos_q      <= pos_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            run_q      <= run_d;
        end
    end

    // Half-cycle delayed copy of the high phase, trims odd ratios to exact 50%
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clk_out  = div_q[0] ? (pos_q & neg_q) : pos_q;
    assign tick     = tick_q;
    assign cur_div  = div_q;
    assign load_err = err_q;
    assign running  = run_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed steps plus random en/load traffic,
// compared every half clock against a period-level reference model.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       div_load;
    logic [7:0] div_val;
    logic       clk_out;
    logic       tick;
    logic [7:0] cur_div;
    logic       load_err;
    logic       running;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current period and the ratio in force
    bit m_run;
    int m_k;
    int m_n;
    int m_pend;
    bit m_pv;
    bit m_tick;
    bit m_err;

    clk_div_prog dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .cur_div  (cur_div),
        .load_err (load_err),
        .running  (running)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output high for exactly N half-cycles of each period: even N from the start,
    // odd N starting half a cycle in.
    function automatic bit hi(input int n, input int h);
        if (n % 2 == 0) return (h < n);
        return (h >= 1) && (h <= n);
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_k    = 0;
        m_n    = 3;
        m_pend = 0;
        m_pv   = 1'b0;
        m_tick = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clk cycle: drive, advance model at posedge, check after both edges
    task automatic step(input bit e, input bit ld, input int v);
        en       = e;
        div_load = ld;
        div_val  = v[7:0];
        @(posedge clk);
        m_err  = ld && (v < 2);
        m_tick = 1'b0;
        if (m_run && (m_k != m_n - 1)) begin
            m_k++;
        end else if (m_run || e) begin
            if (m_pv) begin
                m_n  = m_pend;
                m_pv = 1'b0;
            end
            m_k    = 0;
            m_run  = e;
            m_tick = e;
        end
        if (ld && (v >= 2)) begin
            m_pend = v;
            m_pv   = 1'b1;
        end
        #1;
        chk("tick", tick, m_tick);
        chk("running", running, m_run);
        chk("cur_div", cur_div, m_n);
        chk("load_err", load_err, m_err);
        chk("clk_out_pos", clk_out, m_run && hi(m_n, 2 * m_k));
        @(negedge clk);
        #1;
        chk("clk_out_neg", clk_out, m_run && hi(m_n, 2 * m_k + 1));
        div_load = 1'b0;
    endtask

    initial begin
        int guard;
        reset    = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        model_reset();
        #12;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_cur_div", cur_div, 3);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Default divide-by-3
        repeat (12) step(1, 0, 0);

        // Switch to N=4 at a random phase
        repeat ($urandom_range(0, 2)) step(1, 0, 0);
        step(1, 1, 4);
        repeat (12) step(1, 0, 0);

        // 5 then 7 inside one period: only 7 is applied
        guard = 0;
        while (m_k != 0 && guard < 20) begin
            step(1, 0, 0);
            guard++;
        end
        chk("align_k0", guard < 20, 1);
        step(1, 1, 5);
        step(1, 1, 7);
        repeat (20) step(1, 0, 0);

        // Illegal ratios 1 and 0
        step(1, 1, 1);
        step(1, 0, 0);
        step(1, 1, 0);
        repeat (8) step(1, 0, 0);

        // N=6, drop en at cnt=1, period completes, then restart
        step(1, 1, 6);
        guard = 0;
        while (!(m_n == 6 && m_k == 1) && guard < 30) begin
            step(1, 0, 0);
            guard++;
        end
        chk("reach_n6_k1", guard < 30, 1);
        repeat (8) step(0, 0, 0);
        step(1, 0, 0);
        repeat (6) step(1, 0, 0);

        // Drop en and re-raise before the wrap: run continues without gap
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (8) step(1, 0, 0);

        // Random traffic
        repeat (300) step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 12));

        // Asynchronous reset while clk_out is high, with a pending ratio to discard
        step(1, 1, 8);
        guard = 0;
        while (!(m_run && m_n == 8 && m_k == 1) && guard < 40) begin
            step(1, 0, 0);
            guard++;
        end
        chk("reach_n8_k1", guard < 40, 1);
        step(1, 1, 9);
        chk("pre_rst_clk_out", clk_out, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_clk_out", clk_out, 0);
        chk("arst_tick", tick, 0);
        chk("arst_running", running, 0);
        chk("arst_load_err", load_err, 0);
        chk("arst_cur_div", cur_div, 3);
        model_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        step(1, 0, 0);
        repeat (12) step(1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
